// File: rtl/wb_regfile.sv
// RV32I write-back stage: result select, 32 x XLEN architectural register file,
// two bypassed decode read ports and one raw debug read port.
module wb_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteW,
  input  logic [1:0]      ResultSrcW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ALUResultW,
  input  logic [XLEN-1:0] ReadDataW,
  input  logic [XLEN-1:0] PCPlus4W,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      DbgAddr,
  output logic [XLEN-1:0] ResultW,
  output logic [XLEN-1:0] RD1D,
  output logic [XLEN-1:0] RD2D,
  output logic [XLEN-1:0] DbgData
);

  // No handshake: one write is accepted every cycle unconditionally; stalls and
  // hazards are resolved upstream of this stage.

  logic [XLEN-1:0] regs [NREG];
  logic            we;

  always_comb begin
    ResultW = ALUResultW;
    case (ResultSrcW)
      2'b01:   ResultW = ReadDataW;
      2'b10:   ResultW = PCPlus4W;
      default: ResultW = ALUResultW;  // 00, and reserved 11
    endcase
  end

  // A write in a reset cycle is dropped, so the bypass must not expose it either.
  assign we = RegWriteW && (RdW != 5'd0) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[RdW] <= ResultW;
    end
  end

  always_comb begin
    if (Rs1D == 5'd0)            RD1D = '0;
    else if (we && RdW == Rs1D)  RD1D = ResultW;
    else                         RD1D = regs[Rs1D];
  end

  always_comb begin
    if (Rs2D == 5'd0)            RD2D = '0;
    else if (we && RdW == Rs2D)  RD2D = ResultW;
    else                         RD2D = regs[Rs2D];
  end

  assign DbgData = (DbgAddr == 5'd0) ? '0 : regs[DbgAddr];

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed cases plus randomized traffic
// compared against an array-based model of the register file.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [31:0] PCPlus4W;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [4:0]  DbgAddr;
  logic [31:0] ResultW;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic [31:0] DbgData;

  wb_regfile #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .RdW(RdW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
    .PCPlus4W(PCPlus4W), .Rs1D(Rs1D), .Rs2D(Rs2D), .DbgAddr(DbgAddr),
    .ResultW(ResultW), .RD1D(RD1D), .RD2D(RD2D), .DbgData(DbgData)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m [32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic logic [31:0] model_result();
    case (ResultSrcW)
      2'd1:    return ReadDataW;
      2'd2:    return PCPlus4W;
      default: return ALUResultW;
    endcase
  endfunction

  function automatic logic model_writes();
    return (RegWriteW == 1'b1) && (RdW != 0) && (rst == 1'b0);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic bypass);
    if (a == 0) return 32'h0;
    if (bypass && model_writes() && RdW == a) return model_result();
    return m[a];
  endfunction

  // drivers
  task automatic set_in(input logic r, input logic wen, input logic [1:0] src,
                        input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] ld, input logic [31:0] pc4,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    rst = r; RegWriteW = wen; ResultSrcW = src; RdW = rd;
    ALUResultW = alu; ReadDataW = ld; PCPlus4W = pc4;
    Rs1D = a1; Rs2D = a2; DbgAddr = ad;
  endtask

  // Commit the current cycle into the model, then advance past the edge.
  task automatic step();
    if (rst) begin
      for (int i = 0; i < 32; i++) m[i] = 32'h0;
    end else if (model_writes()) begin
      m[RdW] = model_result();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    #1;
    check({tag, ".res"}, ResultW, model_result());
    check({tag, ".rd1"}, RD1D, model_read(Rs1D, 1'b1));
    check({tag, ".rd2"}, RD2D, model_read(Rs2D, 1'b1));
    check({tag, ".dbg"}, DbgData, model_read(DbgAddr, 1'b0));
  endtask

  task automatic sweep_dbg(input string tag);
    RegWriteW = 1'b0;
    for (int a = 0; a < 32; a++) begin
      DbgAddr = 5'(a);
      #1;
      check(tag, DbgData, m[a]);
    end
  endtask

  task automatic write_reg(input logic [4:0] rd, input logic [31:0] v);
    set_in(1'b0, 1'b1, 2'b00, rd, v, 32'h0, 32'h0, 5'd0, 5'd0, rd);
    step();
  endtask

  logic [31:0] mux_exp [4];

  initial begin
    for (int i = 0; i < 32; i++) m[i] = 32'hx;
    set_in(1'b1, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    step();
    for (int a = 1; a < 32; a += 6) begin
      DbgAddr = 5'(a);
      #1;
      check("reset_init", DbgData, 32'h0);
    end

    // reset clear drops a concurrent write
    write_reg(5'd5, 32'hDEAD_BEEF);
    check("preload_x5", DbgData, 32'hDEAD_BEEF);
    set_in(1'b1, 1'b1, 2'b00, 5'd5, 32'h5555_AAAA, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5);
    check_all("rst_cyc");
    step();
    check("rst_dbg5", DbgData, 32'h0);
    check("rst_rd1_5", RD1D, 32'h0);

    // result mux sweep with writes to x7
    mux_exp[0] = 32'h11; mux_exp[1] = 32'h22; mux_exp[2] = 32'h33; mux_exp[3] = 32'h11;
    for (int s = 0; s < 4; s++) begin
      set_in(1'b0, 1'b1, 2'(s), 5'd7, 32'h11, 32'h22, 32'h33, 5'd0, 5'd0, 5'd7);
      #1;
      check("mux_res", ResultW, mux_exp[s]);
      step();
      check("mux_dbg7", DbgData, mux_exp[s]);
    end

    // same-cycle bypass on both ports
    write_reg(5'd10, 32'h0000_CAFE);
    set_in(1'b0, 1'b1, 2'b00, 5'd10, 32'h1234_5678, 32'h0, 32'h0, 5'd10, 5'd10, 5'd10);
    #1;
    check("byp_rd1", RD1D, 32'h1234_5678);
    check("byp_rd2", RD2D, 32'h1234_5678);
    check("byp_dbg_old", DbgData, 32'h0000_CAFE);
    step();
    check("byp_dbg_new", DbgData, 32'h1234_5678);

    // x0 protection
    set_in(1'b0, 1'b1, 2'b00, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1;
    check("x0_rd1", RD1D, 32'h0);
    step();
    check("x0_rd1_after", RD1D, 32'h0);
    sweep_dbg("x0_sweep");

    // write disabled
    write_reg(5'd3, 32'h1);
    set_in(1'b0, 1'b0, 2'b00, 5'd3, 32'hA5A5_A5A5, 32'h0, 32'h0, 5'd3, 5'd0, 5'd3);
    #1;
    check("wdis_rd1", RD1D, 32'h1);
    step();
    check("wdis_dbg3", DbgData, 32'h1);

    // back-to-back writes to x4
    for (int k = 1; k <= 3; k++) exp_q.push_back(32'(k));
    for (int k = 1; k <= 3; k++) begin
      set_in(1'b0, 1'b1, 2'b00, 5'd4, 32'(k), 32'h0, 32'h0, 5'd0, 5'd4, 5'd4);
      #1;
      check("b2b_rd2", RD2D, exp_q.pop_front());
      step();
    end
    check("b2b_dbg4", DbgData, 32'h3);

    // randomized traffic, addresses biased to a small window for collisions
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a1, a2, ad, rd;
      rd = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      a2 = ($urandom_range(0, 1) == 0) ? rd : 5'($urandom_range(0, 5));
      ad = 5'($urandom_range(0, 7));
      set_in(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
             2'($urandom), rd, $urandom, $urandom, $urandom, a1, a2, ad);
      check_all("rand");
      step();
    end
    sweep_dbg("final_sweep");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
